// File: rtl/object_painter.sv
`default_nettype none
// ============================================================================
// Module      : object_painter
// Description : Moves a solid SPR_W x SPR_H rectangular object on a 320x240
//               pixel canvas. On a move request it erases the previously
//               drawn copy (painting BG_COLOR), then draws the object at the
//               new position. It emits one pixel per cycle in which the
//               downstream selector grants the slot (slot_active).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLOCK_50     in   system clock, rising edge
//   rstn         in   asynchronous active-low reset
//   move_req     in   one-cycle move request (ignored while busy)
//   new_x/new_y  in   requested top-left corner (9 / 8 bits)
//   obj_color    in   object colour (3 bits)
//   slot_active  in   high when the selector forwards this stream
//   VGA_X/VGA_Y  out  registered pixel coordinate
//   VGA_color    out  registered pixel colour
//   plot_enable  out  registered pixel write strobe
//   busy         out  high whenever the FSM is not idle
//   done         out  one-cycle pulse when a move completes
// ============================================================================
module object_painter #(
  parameter int         SPR_W    = 8,
  parameter int         SPR_H    = 8,
  parameter logic [2:0] BG_COLOR = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       rstn,
  input  logic       move_req,
  input  logic [8:0] new_x,
  input  logic [7:0] new_y,
  input  logic [2:0] obj_color,
  input  logic       slot_active,
  output logic [8:0] VGA_X,
  output logic [7:0] VGA_Y,
  output logic [2:0] VGA_color,
  output logic       plot_enable,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ERASE  = 2'd1,
    DRAW   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [3:0] CX_LAST = 4'(SPR_W - 1);
  localparam logic [3:0] CY_LAST = 4'(SPR_H - 1);
  localparam logic [9:0] X_LIMIT = 10'd320;
  localparam logic [8:0] Y_LIMIT = 9'd240;

  state_t     state_q, state_d;
  logic [3:0] cx_q, cx_d;
  logic [3:0] cy_q, cy_d;
  logic [8:0] cur_x_q, cur_x_d;
  logic [7:0] cur_y_q, cur_y_d;
  logic [8:0] tgt_x_q, tgt_x_d;
  logic [7:0] tgt_y_q, tgt_y_d;
  logic [2:0] tgt_col_q, tgt_col_d;
  logic       drawn_q, drawn_d;
  logic [8:0] vga_x_q, vga_x_d;
  logic [7:0] vga_y_q, vga_y_d;
  logic [2:0] vga_color_q, vga_color_d;
  logic       plot_q, plot_d;

  // Pixel address: ERASE walks the old footprint, DRAW the new one. The sums
  // are one bit wider than the coordinate so off-canvas pixels can be clipped
  // rather than wrapping around to the left/top edge.
  logic [8:0] base_x;
  logic [7:0] base_y;
  logic [2:0] pix_col;
  logic [9:0] sum_x;
  logic [8:0] sum_y;

  always_comb begin
    base_x  = (state_q == ERASE) ? cur_x_q : tgt_x_q;
    base_y  = (state_q == ERASE) ? cur_y_q : tgt_y_q;
    pix_col = (state_q == ERASE) ? BG_COLOR : tgt_col_q;
    sum_x   = {1'b0, base_x} + {6'd0, cx_q};
    sum_y   = {1'b0, base_y} + {5'd0, cy_q};
  end

  always_comb begin
    state_d     = state_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    tgt_x_d     = tgt_x_q;
    tgt_y_d     = tgt_y_q;
    tgt_col_d   = tgt_col_q;
    drawn_d     = drawn_q;
    vga_x_d     = vga_x_q;
    vga_y_d     = vga_y_q;
    vga_color_d = vga_color_q;
    plot_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (move_req) begin
          tgt_x_d   = new_x;
          tgt_y_d   = new_y;
          tgt_col_d = obj_color;
          cx_d      = 4'd0;
          cy_d      = 4'd0;
          state_d   = drawn_q ? ERASE : DRAW;
        end
      end

      ERASE, DRAW: begin
        // Counters advance only on granted slots, so a withheld slot neither
        // skips nor repeats a pixel. Clipped pixels still use their slot.
        if (slot_active) begin
          vga_x_d     = sum_x[8:0];
          vga_y_d     = sum_y[7:0];
          vga_color_d = pix_col;
          plot_d      = (sum_x < X_LIMIT) && (sum_y < Y_LIMIT);
          if (cx_q == CX_LAST) begin
            cx_d = 4'd0;
            if (cy_q == CY_LAST) begin
              cy_d    = 4'd0;
              state_d = (state_q == ERASE) ? DRAW : FINISH;
            end else begin
              cy_d = cy_q + 4'd1;
            end
          end else begin
            cx_d = cx_q + 4'd1;
          end
        end
      end

      FINISH: begin
        cur_x_d = tgt_x_q;
        cur_y_d = tgt_y_q;
        drawn_d = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cx_q        <= 4'd0;
      cy_q        <= 4'd0;
      cur_x_q     <= 9'd0;
      cur_y_q     <= 8'd0;
      tgt_x_q     <= 9'd0;
      tgt_y_q     <= 8'd0;
      tgt_col_q   <= 3'd0;
      drawn_q     <= 1'b0;
      vga_x_q     <= 9'd0;
      vga_y_q     <= 8'd0;
      vga_color_q <= 3'd0;
      plot_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      tgt_x_q     <= tgt_x_d;
      tgt_y_q     <= tgt_y_d;
      tgt_col_q   <= tgt_col_d;
      drawn_q     <= drawn_d;
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      vga_color_q <= vga_color_d;
      plot_q      <= plot_d;
    end
  end

  assign VGA_X       = vga_x_q;
  assign VGA_Y       = vga_y_q;
  assign VGA_color   = vga_color_q;
  assign plot_enable = plot_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FINISH);

endmodule
`default_nettype wire

// File: tb/tb_object_painter.sv
`default_nettype none
// ============================================================================
// Module      : tb_object_painter
// Description : Self-checking bench for object_painter. A reference model
//               queues every expected plotted pixel when a move is issued; a
//               negedge monitor pops and compares each plotted pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_object_painter;

  localparam logic [2:0] BG = 3'b000;

  logic       clk;
  logic       rstn;
  logic       move_req;
  logic [8:0] new_x;
  logic [7:0] new_y;
  logic [2:0] obj_color;
  logic       slot_active;
  logic [8:0] VGA_X;
  logic [7:0] VGA_Y;
  logic [2:0] VGA_color;
  logic       plot_enable;
  logic       busy;
  logic       done;

  object_painter #(.SPR_W(8), .SPR_H(8), .BG_COLOR(BG)) dut (
    .CLOCK_50    (clk),
    .rstn        (rstn),
    .move_req    (move_req),
    .new_x       (new_x),
    .new_y       (new_y),
    .obj_color   (obj_color),
    .slot_active (slot_active),
    .VGA_X       (VGA_X),
    .VGA_Y       (VGA_Y),
    .VGA_color   (VGA_color),
    .plot_enable (plot_enable),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int plot_cnt = 0;

  logic [19:0] exp_q[$];

  // Reference model state
  logic [8:0] m_cur_x = 9'd0;
  logic [7:0] m_cur_y = 8'd0;
  bit         m_drawn = 1'b0;

  task automatic push_rect(input logic [8:0] bx, input logic [7:0] by, input logic [2:0] col);
    for (int yy = 0; yy < 8; yy++) begin
      for (int xx = 0; xx < 8; xx++) begin
        int px;
        int py;
        px = int'(bx) + xx;
        py = int'(by) + yy;
        if (px < 320 && py < 240)
          exp_q.push_back({9'(px), 8'(py), col});
      end
    end
  endtask

  task automatic model_move(input logic [8:0] x, input logic [7:0] y, input logic [2:0] c);
    if (m_drawn) push_rect(m_cur_x, m_cur_y, BG);
    push_rect(x, y, c);
    m_cur_x = x;
    m_cur_y = y;
    m_drawn = 1'b1;
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Pixel monitor / scoreboard
  always @(negedge clk) begin
    if (rstn && plot_enable) begin
      plot_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pixel_extra: got (%0d,%0d,%0b) expected none", VGA_X, VGA_Y, VGA_color);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if ({VGA_X, VGA_Y, VGA_color} !== e) begin
          errors++;
          $display("FAIL pixel: got (%0d,%0d,%0b) expected (%0d,%0d,%0b)",
                   VGA_X, VGA_Y, VGA_color, e[19:11], e[10:3], e[2:0]);
        end
      end
    end
  end

  task automatic check_outputs_zero(input string name);
    check({name, "_vga"}, int'({VGA_X, VGA_Y, VGA_color}), 0);
    check({name, "_plot"}, int'(plot_enable), 0);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_done"}, int'(done), 0);
  endtask

  task automatic do_reset();
    #2 rstn = 1'b0;
    exp_q.delete();
    m_cur_x = 9'd0;
    m_cur_y = 8'd0;
    m_drawn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // Issue one move and run it to completion. inject_at > 0 pulses a second,
  // conflicting move_req in that cycle of the operation.
  task automatic do_move(input logic [8:0] x, input logic [7:0] y, input logic [2:0] c,
                         input bit toggle, input int exp_plots, input int exp_busy,
                         input int inject_at);
    int k;
    int busy_cnt;
    int done_cnt;
    model_move(x, y, c);
    plot_cnt = 0;
    busy_cnt = 0;
    done_cnt = 0;
    @(posedge clk);
    #1;
    new_x = x; new_y = y; obj_color = c;
    move_req = 1'b1;
    slot_active = 1'b1;
    @(posedge clk);
    #1;
    move_req = 1'b0;
    k = 0;
    while (k < 2000) begin
      @(negedge clk);
      if (!busy) break;
      busy_cnt++;
      if (done) done_cnt++;
      @(posedge clk);
      #1;
      k++;
      slot_active = toggle ? (k % 2 == 0) : 1'b1;
      if (k == inject_at) begin
        new_x = 9'd200; new_y = 8'd150; obj_color = 3'b101;
        move_req = 1'b1;
      end else begin
        move_req = 1'b0;
      end
    end
    move_req = 1'b0;
    slot_active = 1'b1;
    if (k >= 2000) begin
      checks++;
      errors++;
      $display("FAIL move_timeout: got busy after %0d cycles expected idle", k);
    end
    check("busy_cycles", busy_cnt, exp_busy);
    check("plot_count", plot_cnt, exp_plots);
    check("done_pulses", done_cnt, 1);
    check("queue_left", exp_q.size(), 0);
  endtask

  typedef struct {
    bit         rst_first;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
    bit         toggle;
    int         plots;
    int         busy_n;
  } vec_t;

  vec_t tbl[5];

  initial begin
    rstn = 1'b0;
    move_req = 1'b0;
    new_x = 9'd0;
    new_y = 8'd0;
    obj_color = 3'd0;
    slot_active = 1'b1;

    // first draw only; erase+draw; toggled grant after reset; clipped corner;
    // move to the same clipped position
    tbl[0] = '{1'b0, 9'd10,  8'd20,  3'b100, 1'b0, 64, 65};
    tbl[1] = '{1'b0, 9'd50,  8'd60,  3'b010, 1'b0, 128, 129};
    tbl[2] = '{1'b1, 9'd10,  8'd20,  3'b100, 1'b1, 64, 128};
    tbl[3] = '{1'b0, 9'd316, 8'd236, 3'b111, 1'b0, 80, 129};
    tbl[4] = '{1'b0, 9'd316, 8'd236, 3'b101, 1'b0, 32, 129};

    #5;
    check_outputs_zero("reset");
    @(posedge clk);
    #1 rstn = 1'b1;

    for (int i = 0; i < 5; i++) begin
      if (tbl[i].rst_first) do_reset();
      do_move(tbl[i].x, tbl[i].y, tbl[i].c, tbl[i].toggle, tbl[i].plots, tbl[i].busy_n, 0);
    end

    // Conflicting request mid-DRAW must be ignored; the following move then
    // erases at the first requested position, not the injected one.
    do_move(9'd100, 8'd100, 3'b110, 1'b0, 80, 129, 80);
    do_move(9'd30, 8'd40, 3'b011, 1'b0, 128, 129, 0);

    // Reset during ERASE abandons the move; the next move skips ERASE.
    model_move(9'd60, 8'd70, 3'b001);
    @(posedge clk);
    #1;
    new_x = 9'd60; new_y = 8'd70; obj_color = 3'b001;
    move_req = 1'b1;
    @(posedge clk);
    #1 move_req = 1'b0;
    repeat (10) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    exp_q.delete();
    m_cur_x = 9'd0;
    m_cur_y = 8'd0;
    m_drawn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    do_move(9'd60, 8'd70, 3'b001, 1'b0, 64, 65, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
